// File: rtl/n64_poll_controller.sv
// N64 controller link sequencer: periodic poll command 0x01, 32-bit reply capture, button decode.
// Define N64_STICK_EN to add the analog stick outputs stick_x_o / stick_y_o.
module n64_poll_controller #(
    parameter int CYC_PER_US  = 14,
    parameter int POLL_CYCLES = 233333,
    parameter int TIMEOUT_US  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        n64_i,
    output logic        n64_oe_o,
    output logic [11:0] buttons_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        err_o
`ifdef N64_STICK_EN
    ,
    output logic [7:0]  stick_x_o,
    output logic [7:0]  stick_y_o
`endif
);
    localparam int T1US    = CYC_PER_US;
    localparam int T2US    = 2 * CYC_PER_US;
    localparam int T3US    = 3 * CYC_PER_US;
    localparam int TO_CYC  = TIMEOUT_US * CYC_PER_US;
    localparam int CNT_MAX = (TO_CYC > T3US) ? TO_CYC : T3US;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(POLL_CYCLES);

    localparam logic [CW-1:0] C1_M1 = CW'(T1US - 1);
    localparam logic [CW-1:0] C2_M1 = CW'(T2US - 1);
    localparam logic [CW-1:0] C3_M1 = CW'(T3US - 1);
    localparam logic [CW-1:0] TO_M1 = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] C_SAT = CW'(CNT_MAX);
    localparam logic [PW-1:0] P_M1  = PW'(POLL_CYCLES - 1);
    localparam logic [7:0]    CMD   = 8'h01;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TX_LOW    = 3'd1;
    localparam logic [2:0] TX_HIGH   = 3'd2;
    localparam logic [2:0] RX_WAIT   = 3'd3;
    localparam logic [2:0] RX_SAMPLE = 3'd4;
    localparam logic [2:0] RX_STOP   = 3'd5;

    logic          meta_q, sync_q0, sync_q1;
    logic          fall;
    logic [PW-1:0] poll_q;
    logic          poll_wrap;
    logic [2:0]    state_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic [3:0]    tx_idx_q;
    logic [5:0]    rx_cnt_q;
    logic [31:0]   shreg_q;
    logic [11:0]   buttons_q;
    logic          valid_q, err_q;
    logic          cmd_bit;
    logic [CW-1:0] low_m1, high_m1;
    logic          unused_bits;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            sync_q0 <= 1'b1;
            sync_q1 <= 1'b1;
        end else begin
            meta_q  <= n64_i;
            sync_q0 <= meta_q;
            sync_q1 <= sync_q0;
        end
    end

    assign fall = sync_q1 & ~sync_q0;

    assign poll_wrap = (poll_q == P_M1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) poll_q <= '0;
        else         poll_q <= poll_wrap ? '0 : poll_q + 1'b1;
    end

    // Index 8 is the console stop bit, which is timed like a '1' low phase.
    assign cmd_bit = tx_idx_q[3] ? 1'b1 : CMD[~tx_idx_q[2:0]];
    assign low_m1  = cmd_bit ? C1_M1 : C3_M1;
    assign high_m1 = cmd_bit ? C3_M1 : C1_M1;
    assign cnt_inc = (cnt_q == C_SAT) ? cnt_q : cnt_q + 1'b1;

`ifdef N64_STICK_EN
    logic [7:0] stick_x_q, stick_y_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_idx_q  <= '0;
            rx_cnt_q  <= '0;
            shreg_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef N64_STICK_EN
            stick_x_q <= '0;
            stick_y_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (poll_wrap) begin
                        state_q  <= TX_LOW;
                        cnt_q    <= '0;
                        tx_idx_q <= '0;
                    end
                end
                TX_LOW: begin
                    if (cnt_q == low_m1) begin
                        cnt_q    <= '0;
                        rx_cnt_q <= '0;
                        state_q  <= tx_idx_q[3] ? RX_WAIT : TX_HIGH;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                TX_HIGH: begin
                    if (cnt_q == high_m1) begin
                        cnt_q    <= '0;
                        tx_idx_q <= tx_idx_q + 1'b1;
                        state_q  <= TX_LOW;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RX_WAIT: begin
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= RX_SAMPLE;
                    end else if (cnt_q == TO_M1) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RX_SAMPLE: begin
                    if (cnt_q == C2_M1) begin
                        shreg_q  <= {shreg_q[30:0], sync_q0};
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                        cnt_q    <= '0;
                        state_q  <= (rx_cnt_q == 6'd31) ? RX_STOP : RX_WAIT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RX_STOP: begin
                    // Outputs only change here, so a cut-short reply never leaks out.
                    if (sync_q0) begin
                        buttons_q <= {shreg_q[31:24], shreg_q[21:18]};
                        valid_q   <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= IDLE;
`ifdef N64_STICK_EN
                        stick_x_q <= shreg_q[15:8];
                        stick_y_q <= shreg_q[7:0];
`endif
                    end else if (cnt_q == TO_M1) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef N64_STICK_EN
    assign stick_x_o   = stick_x_q;
    assign stick_y_o   = stick_y_q;
    assign unused_bits = ^{shreg_q[23:22], shreg_q[17:16]};
`else
    assign unused_bits = ^{shreg_q[23:22], shreg_q[17:0]};
`endif

    assign n64_oe_o  = (state_q == TX_LOW);
    assign busy_o    = (state_q != IDLE);
    assign buttons_o = buttons_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;

endmodule
